// File: rtl/whiten_frame_ctrl.sv
// Serial frame builder: preamble, sync word, externally whitened payload, optional CRC-8.
// Optional CRC-8 trailer is enabled by defining WHITEN_FRAME_CTRL_CRC8_EN.
module whiten_frame_ctrl #(
  parameter int          PREAMBLE_BITS = 16,
  parameter logic [15:0] SYNC_WORD     = 16'hD391
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       whiten_trigger,
  output logic       whiten_data,
  input  logic       wh_result,
  output logic       tx_bit,
  output logic       tx_valid,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_SYNC  = 3'd2;
  localparam logic [2:0] S_PAY   = 3'd3;
  localparam logic [2:0] S_CRC   = 3'd4;
  localparam logic [2:0] S_FLUSH = 3'd5;
`ifdef WHITEN_FRAME_CTRL_CRC8_EN
  localparam logic [2:0] S_TAIL  = S_CRC;
`else
  localparam logic [2:0] S_TAIL  = S_FLUSH;
`endif

  logic [2:0] state_q, state_d;
  logic [7:0] slot_q, slot_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] len_q, len_d;
  logic [7:0] data_q, data_d;
  logic       underrun_q, underrun_d;
  logic       tx_valid_q, tx_raw_q, wh_sel_q;
`ifdef WHITEN_FRAME_CTRL_CRC8_EN
  logic [7:0] crc_q, crc_d;
`endif

  logic raw_bit, whitened, emit, uf;

  always_comb begin
    raw_bit = 1'b0;
    case (state_q)
      S_PRE:  raw_bit = ~slot_q[0];
      S_SYNC: raw_bit = SYNC_WORD[~slot_q[3:0]];
      S_PAY:  raw_bit = data_q[~bit_q];
`ifdef WHITEN_FRAME_CTRL_CRC8_EN
      S_CRC:  raw_bit = crc_q[~bit_q];
`endif
      default: raw_bit = 1'b0;
    endcase
  end

`ifdef WHITEN_FRAME_CTRL_CRC8_EN
  assign whitened = (state_q == S_PAY) || (state_q == S_CRC);
`else
  assign whitened = (state_q == S_PAY);
`endif
  assign emit     = (state_q == S_PRE) || (state_q == S_SYNC) || whitened;
  // A fetch happens in the last slot of sync and of every non-final byte.
  assign in_ready = ((state_q == S_SYNC) && (slot_q == 8'd15) && (len_q != 8'd0)) ||
                    ((state_q == S_PAY) && (bit_q == 3'd7) && (byte_q != len_q - 8'd1));
  assign uf       = in_ready && !in_valid;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    len_d      = len_q;
    data_d     = data_q;
    underrun_d = underrun_q;
`ifdef WHITEN_FRAME_CTRL_CRC8_EN
    crc_d      = crc_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_PRE;
        len_d      = len;
        slot_d     = 8'd0;
        underrun_d = 1'b0;
      end
      S_PRE: begin
        slot_d = slot_q + 8'd1;
        if (slot_q == 8'(PREAMBLE_BITS - 1)) begin
          state_d = S_SYNC;
          slot_d  = 8'd0;
        end
      end
      S_SYNC: begin
        slot_d = slot_q + 8'd1;
        if (slot_q == 8'd15) begin
          slot_d = 8'd0;
          bit_d  = 3'd0;
          byte_d = 8'd0;
`ifdef WHITEN_FRAME_CTRL_CRC8_EN
          crc_d  = 8'h00;
`endif
          if (len_q == 8'd0) state_d = S_TAIL;
          else if (in_valid) begin
            state_d = S_PAY;
            data_d  = in_data;
          end else begin
            state_d    = S_IDLE;
            underrun_d = 1'b1;
          end
        end
      end
      S_PAY: begin
        bit_d = bit_q + 3'd1;
`ifdef WHITEN_FRAME_CTRL_CRC8_EN
        crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ raw_bit) ? 8'h07 : 8'h00);
`endif
        if (bit_q == 3'd7) begin
          if (byte_q == len_q - 8'd1) state_d = S_TAIL;
          else if (in_valid) begin
            data_d = in_data;
            byte_d = byte_q + 8'd1;
          end else begin
            state_d    = S_IDLE;
            underrun_d = 1'b1;
          end
        end
      end
`ifdef WHITEN_FRAME_CTRL_CRC8_EN
      S_CRC: begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_FLUSH;
      end
`endif
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      slot_q     <= 8'd0;
      bit_q      <= 3'd0;
      byte_q     <= 8'd0;
      len_q      <= 8'd0;
      data_q     <= 8'd0;
      underrun_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_raw_q   <= 1'b0;
      wh_sel_q   <= 1'b0;
`ifdef WHITEN_FRAME_CTRL_CRC8_EN
      crc_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      len_q      <= len_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
      // Every slot is shown one cycle late; an underrun kills the pending bit.
      tx_valid_q <= emit && !uf;
      tx_raw_q   <= emit && !whitened && raw_bit;
      wh_sel_q   <= whitened && !uf;
`ifdef WHITEN_FRAME_CTRL_CRC8_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign whiten_trigger = whitened;
  assign whiten_data    = whitened && raw_bit;
  assign tx_bit         = wh_sel_q ? wh_result : tx_raw_q;
  assign tx_valid       = tx_valid_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FLUSH);
  assign underrun       = underrun_q;

endmodule

// File: tb/tb_whiten_frame_ctrl.sv
// Directed table-driven bench for whiten_frame_ctrl with an external whitening scrambler model.
// Expectations follow WHITEN_FRAME_CTRL_CRC8_EN when it is defined for the build.
module tb_whiten_frame_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       wh_result = 1'b0;
  logic       in_ready, whiten_trigger, whiten_data, tx_bit, tx_valid, busy, done, underrun;

  int n_tests = 0;
  int n_fail  = 0;

  whiten_frame_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .whiten_trigger(whiten_trigger), .whiten_data(whiten_data), .wh_result(wh_result),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clock = ~clock;

  // External whitener: self-synchronising scrambler x^7+x^4+1, held at zero while idle.
  logic [6:0] lfsr = 7'd0;
  logic       wbit;
  assign wbit = whiten_data ^ lfsr[6] ^ lfsr[3];
  always @(posedge clock) begin
    if (whiten_trigger) begin
      lfsr      <= {lfsr[5:0], wbit};
      wh_result <= wbit;
    end else begin
      lfsr      <= 7'd0;
      wh_result <= 1'b0;
    end
  end

`ifdef WHITEN_FRAME_CTRL_CRC8_EN
  localparam int CB = 8;
`else
  localparam int CB = 0;
`endif

  typedef struct {
    logic [7:0]      len;
    logic [2:0][7:0] b;      // b[0] is the first payload byte
    int              drop;   // index of the in_ready with in_valid=0, -1 for none
    int              ntx;
    logic [63:0]     stream;
    int              trig;
    int              irdy;
    int              done_cyc; // start cycle counts as cycle 1; 0 means no done
    logic            uf;
  } vec_t;

  typedef struct {
    int          ntx;
    logic [63:0] stream;
    int          trig;
    int          irdy;
    int          done_cyc;
    logic        uf;
    logic        after_uf;
    logic        timeout;
  } res_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, output res_t r);
    bit fin;
    r = '{default: 0};
    fin = 0;
    @(negedge clock);
    start = 1'b1; len = v.len; in_valid = 1'b0;
    for (int c = 1; c <= 400 && !fin; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (tx_valid) begin r.ntx++; r.stream = {r.stream[62:0], tx_bit}; end
      if (whiten_trigger) r.trig++;
      if (done) r.done_cyc = c + 1;
      if (underrun && !r.uf) begin
        r.uf = 1'b1;
        r.after_uf = whiten_trigger | busy | tx_valid;
      end
      in_valid = 1'b0;
      if (in_ready) begin
        if (r.irdy < 3) in_data = v.b[r.irdy];
        in_valid = (r.irdy != v.drop);
        r.irdy++;
      end
      if (!busy) fin = 1;
    end
    r.timeout = !fin;
  endtask

  vec_t vecs [5];
  res_t r;
  int   dc;
  bit   seen;

  initial begin
    vecs[0] = '{len: 8'd0, b: 24'h0, drop: -1, ntx: 32 + CB,
                stream: 64'h0000_0000_AAAA_D391 << CB,
                trig: CB, irdy: 0, done_cyc: 34 + CB, uf: 1'b0};
`ifdef WHITEN_FRAME_CTRL_CRC8_EN
    vecs[1] = '{len: 8'd1, b: {8'h00, 8'h00, 8'hFF}, drop: -1, ntx: 48,
                stream: {32'hAAAA_D391, 8'hF1, 8'h01}, trig: 16, irdy: 1, done_cyc: 50, uf: 1'b0};
    vecs[2] = '{len: 8'd1, b: {8'h00, 8'h00, 8'h01}, drop: -1, ntx: 48,
                stream: {32'hAAAA_D391, 8'h01, 8'h14}, trig: 16, irdy: 1, done_cyc: 50, uf: 1'b0};
`else
    vecs[1] = '{len: 8'd1, b: {8'h00, 8'h00, 8'hFF}, drop: -1, ntx: 40,
                stream: {32'hAAAA_D391, 8'hF1}, trig: 8, irdy: 1, done_cyc: 42, uf: 1'b0};
    vecs[2] = '{len: 8'd1, b: {8'h00, 8'h00, 8'h01}, drop: -1, ntx: 40,
                stream: {32'hAAAA_D391, 8'h01}, trig: 8, irdy: 1, done_cyc: 42, uf: 1'b0};
`endif
    vecs[3] = '{len: 8'd3, b: {8'h00, 8'h00, 8'h00}, drop: 1, ntx: 39,
                stream: {32'hAAAA_D391, 7'd0}, trig: 8, irdy: 2, done_cyc: 0, uf: 1'b1};
    vecs[4] = '{len: 8'd1, b: {8'h00, 8'h00, 8'hFF}, drop: 0, ntx: 31,
                stream: 64'(32'hAAAA_D391 >> 1), trig: 0, irdy: 1, done_cyc: 0, uf: 1'b1};

    repeat (3) @(negedge clock);
    check("reset_outs", {in_ready, whiten_trigger, whiten_data, tx_bit, tx_valid, busy, done, underrun}, 0);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], r);
      check($sformatf("v%0d_timeout", i), r.timeout, 0);
      check($sformatf("v%0d_ntx", i), r.ntx, vecs[i].ntx);
      check($sformatf("v%0d_stream", i), r.stream, vecs[i].stream);
      check($sformatf("v%0d_trig", i), r.trig, vecs[i].trig);
      check($sformatf("v%0d_irdy", i), r.irdy, vecs[i].irdy);
      check($sformatf("v%0d_done", i), r.done_cyc, vecs[i].done_cyc);
      check($sformatf("v%0d_uf", i), r.uf, vecs[i].uf);
      if (vecs[i].uf) check($sformatf("v%0d_after_uf", i), r.after_uf, 0);
    end

    // Reset pulse in the middle of the payload aborts the frame.
    @(negedge clock);
    start = 1'b1; len = 8'd2; in_valid = 1'b1; in_data = 8'h55;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (whiten_trigger) seen = 1;
    end
    check("rst_reach_payload", seen, 1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid_outs", {in_ready, whiten_trigger, whiten_data, tx_bit, tx_valid, busy, done, underrun}, 0);
    reset = 1'b1; in_valid = 1'b0;
    run_vec(vecs[1], r);
    check("rst_after_stream", r.stream, vecs[1].stream);
    check("rst_after_done", r.done_cyc, vecs[1].done_cyc);

    // Start held while busy and during done is ignored; start in the next idle cycle launches.
    @(negedge clock);
    start = 1'b1; len = 8'd0;
    dc = 0;
    for (int c = 1; c <= 100 && dc == 0; c++) begin
      @(negedge clock);
      start = 1'b1; len = 8'd5;
      if (done) dc = c + 1;
    end
    check("busy_start_ign", dc, 34 + CB);
    len = 8'd0;
    @(negedge clock);
    check("done_start_ign", busy, 0);
    dc = 0;
    for (int c = 1; c <= 100 && dc == 0; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (c == 1) check("idle_start_busy", busy, 1);
      if (done) dc = c + 1;
    end
    check("idle_start_done", dc, 34 + CB);
    @(negedge clock);
    check("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/whiten_frame_ctrl.md
WHITEN_FRAME_CTRL -- requirements
Module: whiten_frame_ctrl

Interface
REQ-001 SHALL have parameter PREAMBLE_BITS, default 16: count of alternating preamble bits, starting with 1 (1010...).
REQ-002 SHALL have parameter SYNC_WORD, default 16'hD391: 16-bit sync word, sent MSB first.
REQ-003 SHALL have ports `clock`  in  1  bit clock; every cycle is one bit slot.
REQ-004 SHALL have ports `reset`  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports start  in  1  frame request, sampled only when busy=0.
REQ-006 SHALL have ports len  in  8  payload byte count, captured with start; 0 is legal.
REQ-007 SHALL have ports in_data  in  8  payload byte, sent MSB first.
REQ-008 SHALL have ports in_valid  in  1  in_data is valid.
REQ-009 SHALL have ports in_ready  out  1  byte fetch strobe.
REQ-010 SHALL have ports whiten_trigger  out  1  enable for the external whitening LFSR.
REQ-011 SHALL have ports whiten_data  out  1  raw payload bit to the whitening LFSR.
REQ-012 SHALL have ports wh_result  in  1  registered whitened bit returned by the LFSR.
REQ-013 SHALL have ports tx_bit  out  1  serial output bit.
REQ-014 SHALL have ports tx_valid  out  1  tx_bit is meaningful.
REQ-015 SHALL have ports busy  out  1  frame in progress.
REQ-016 SHALL have ports done  out  1  one-cycle pulse at frame completion.
REQ-017 SHALL have ports underrun  out  1  sticky flag, cleared by the next accepted start.

Function
REQ-018 SHALL implement FSM states IDLE, PREAMBLE, SYNC, PAYLOAD, (CRC), FLUSH.
REQ-019 SHALL, in IDLE with start=1, capture len and enter PREAMBLE next cycle; start is ignored while busy=1.
REQ-020 SHALL emit exactly one internal bit per cycle in PREAMBLE/SYNC/PAYLOAD/CRC; busy=1 in every state except IDLE.
REQ-021 SHALL present each internal bit on tx_bit exactly one cycle after its slot, with tx_valid=1 for that cycle.
REQ-022 SHALL, for preamble and sync bits, drive tx_bit from an internal register, not from wh_result.
REQ-023 SHALL, for payload bits, hold whiten_trigger=1 continuously, drive whiten_data with the raw bit, and drive tx_bit=wh_result the next cycle.
REQ-024 SHALL hold whiten_trigger=0 outside whitened slots, so the LFSR restarts from zero state in every frame.
REQ-025 SHALL pulse in_ready for one cycle in the last slot of the sync word and in the last bit slot of each payload byte except the final byte.
REQ-026 SHALL, when in_ready=1, latch in_data if in_valid=1 for use in the next slot.
REQ-027 SHALL treat in_valid=0 during an in_ready cycle as underrun: set underrun, drop whiten_trigger and tx_valid next cycle, return to IDLE, and issue no done.
REQ-028 SHALL, for len=0, go from SYNC to FLUSH, or to CRC when CRC8 is enabled; no in_ready is issued for payload.
REQ-029 SHALL use FLUSH as a single cycle that emits the final delayed bit (tx_valid=1), pulses done, then enters IDLE; busy drops in the IDLE cycle.
REQ-030 SHALL keep an 8-bit payload byte counter and a 3-bit bit counter; the byte counter SHALL never wrap, since len ≤ 255 terminates it.
REQ-031 SHALL accept a start asserted in the cycle done=1 only in the following IDLE cycle.

Reset
REQ-032 SHALL, while reset=0 at a clock edge, set state=IDLE and force in_ready, whiten_trigger, whiten_data, tx_bit, tx_valid, busy, done and underrun to 0.
REQ-033 SHALL treat reset asserted mid-frame as an immediate abort, with no done pulse and underrun cleared.

Configuration
REQ-034 SHALL, when macro WHITEN_FRAME_CTRL_CRC8_EN is defined, compute a CRC-8 over the raw payload bits (poly 0x07, init 0x00, MSB first).
REQ-035 SHALL, with WHITEN_FRAME_CTRL_CRC8_EN defined, append the CRC in a CRC state of 8 slots, sent MSB first, whitened, with whiten_trigger still held high.
REQ-036 SHALL, without WHITEN_FRAME_CTRL_CRC8_EN, omit the CRC state and logic; the frame ends after the payload.

Verification
REQ-037 SHALL cover: start with len=0, CRC off -> tx_valid for 32 cycles, tx_bits 1010...10 then D391 MSB first, done in cycle 34 after start, whiten_trigger never 1.
REQ-038 SHALL cover: len=1, in_data=0xFF -> in_ready once (last sync slot), whiten_trigger high for exactly 8 cycles, tx_bit payload equals whitening model of 0xFF from zero seed.
REQ-039 SHALL cover: len=3, in_valid dropped at the second in_ready -> underrun=1, whiten_trigger=0 next cycle, IDLE, no done.
REQ-040 SHALL cover: reset=0 for one cycle mid-payload -> all outputs 0 next cycle; a new start then produces a correct frame.
REQ-041 SHALL cover: CRC on, len=1, in_data=0x01 -> CRC 0x07 appended whitened, whiten_trigger high for 16 cycles, done after the CRC.
REQ-042 SHALL cover: start asserted while busy, and in the done cycle -> ignored; start in the next IDLE cycle launches a frame.
